// File: rtl/regfile_pkg.sv
// Shared register-file types and constants.
// Default sizes follow the core's XLEN/NREG.
package regfile_pkg;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int RF_ZERO_ADDR = 0;

   typedef logic [XLEN-1:0] rf_data_t;
   typedef logic [$clog2(NREG)-1:0] rf_addr_t;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Register-file bus: read ports, writeback,
// reservation and flush.
interface regfile_scoreboard_if
   import regfile_pkg::*;
#(
   parameter int WIDTH  = XLEN,
   parameter int N      = NREG,
   parameter int NUM_RD = 2
);
   localparam int AW = $clog2(N);
   localparam int CW = $clog2(N + 1);

   logic [NUM_RD-1:0]             rd_en;
   logic [NUM_RD-1:0][AW-1:0]     rd_addr;
   logic [NUM_RD-1:0][WIDTH-1:0]  rd_data;
   logic [NUM_RD-1:0]             rd_busy;
   logic                          wr_en;
   logic [AW-1:0]                 wr_addr;
   logic [WIDTH-1:0]              wr_data;
   logic                          rsv_en;
   logic [AW-1:0]                 rsv_addr;
   logic                          rsv_ready;
   logic                          flush;
   logic [CW-1:0]                 busy_count;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data,
      output rsv_en, rsv_addr, flush,
      input  rd_data, rd_busy, rsv_ready, busy_count
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
      input  rsv_en, rsv_addr, flush,
      output rd_data, rd_busy, rsv_ready, busy_count
   );
endinterface

// File: rtl/regfile_read_port.sv
// One read port: zero/range masking, write bypass
// and busy masking on top of the raw array read.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int WIDTH     = XLEN,
   parameter int N         = NREG,
   parameter int ZERO_REG0 = 1,
   parameter int BYPASS    = 1,
   localparam int AW = $clog2(N)
) (
   input  logic             en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] reg_data,
   input  logic             reg_busy,
   input  logic             wr_vld,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] data,
   output logic             busy
);
   localparam logic [AW:0]   NV = (AW + 1)'(N);
   localparam logic [AW-1:0] ZA = AW'(RF_ZERO_ADDR);

   logic legal;
   logic byp;

   // Priority: disabled, illegal address, bypass, stored value.
   always_comb begin
      legal = ({1'b0, addr} < NV) &&
              !(ZERO_REG0 != 0 && addr == ZA);
      byp   = (BYPASS != 0) && wr_vld && (wr_addr == addr);
      data  = '0;
      busy  = 1'b0;
      if (en && legal) begin
         data = byp ? wr_data : reg_data;
         busy = reg_busy && !byp;
      end
   end
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with pending-write scoreboard:
// storage, busy bits, reservations, busy counter.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int WIDTH     = XLEN,
   parameter int N         = NREG,
   parameter int NUM_RD    = 2,
   parameter int ZERO_REG0 = 1,
   parameter int BYPASS    = 1
) (
   input logic clk,
   input logic rstn,
   regfile_scoreboard_if.slave bus
);
   localparam int AW = $clog2(N);
   localparam int CW = $clog2(N + 1);
   localparam logic [AW:0]   NV = (AW + 1)'(N);
   localparam logic [AW-1:0] ZA = AW'(RF_ZERO_ADDR);

   logic [WIDTH-1:0] regs [N];
   logic [N-1:0]     busy;
   logic [CW-1:0]    count;

   logic wr_ok;
   logic wr_rel;
   logic rsv_in;
   logic rsv_busy;
   logic rsv_ok;

   logic [NUM_RD-1:0][WIDTH-1:0] rd_raw;
   logic [NUM_RD-1:0]            rd_bsy;
   logic [NUM_RD-1:0][WIDTH-1:0] rd_d;
   logic [NUM_RD-1:0]            rd_b;

   function automatic logic legal(input logic [AW-1:0] a);
      return ({1'b0, a} < NV) &&
             !(ZERO_REG0 != 0 && a == ZA);
   endfunction

   // Write legality and reservation acceptance.
   always_comb begin
      wr_ok    = bus.wr_en && legal(bus.wr_addr);
      wr_rel   = wr_ok && busy[bus.wr_addr];
      rsv_in   = legal(bus.rsv_addr);
      rsv_busy = rsv_in && busy[bus.rsv_addr];
      rsv_ok   = bus.rsv_en && !bus.flush && rsv_in &&
                 (!rsv_busy ||
                  (bus.wr_en && bus.wr_addr == bus.rsv_addr));
   end

   // Raw array read per port, guarded against out-of-range.
   always_comb begin
      for (int p = 0; p < NUM_RD; p++) begin
         rd_raw[p] = '0;
         rd_bsy[p] = 1'b0;
         if ({1'b0, bus.rd_addr[p]} < NV) begin
            rd_raw[p] = regs[bus.rd_addr[p]];
            rd_bsy[p] = busy[bus.rd_addr[p]];
         end
      end
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      regfile_read_port #(
         .WIDTH     (WIDTH),
         .N         (N),
         .ZERO_REG0 (ZERO_REG0),
         .BYPASS    (BYPASS)
      ) u_rp (
         .en       (bus.rd_en[g]),
         .addr     (bus.rd_addr[g]),
         .reg_data (rd_raw[g]),
         .reg_busy (rd_bsy[g]),
         .wr_vld   (wr_ok),
         .wr_addr  (bus.wr_addr),
         .wr_data  (bus.wr_data),
         .data     (rd_d[g]),
         .busy     (rd_b[g])
      );
   end

   assign bus.rd_data    = rd_d;
   assign bus.rd_busy    = rd_b;
   assign bus.rsv_ready  = rsv_ok;
   assign bus.busy_count = count;

   // Register storage; flush never touches contents.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Busy bits: a reservation overrides a same-cycle release.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy <= '0;
      end else if (bus.flush) begin
         busy <= '0;
      end else begin
         if (wr_ok)  busy[bus.wr_addr]  <= 1'b0;
         if (rsv_ok) busy[bus.rsv_addr] <= 1'b1;
      end
   end

   // Busy counter tracks the population of the busy vector.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (bus.flush) begin
         count <= '0;
      end else begin
         count <= count + CW'(rsv_ok) - CW'(wr_rel);
      end
   end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default
// instance (N=32, bypass) and N=20 without bypass.
module tb_regfile_scoreboard;
   import regfile_pkg::*;

   logic clk = 1'b0;
   logic rstn;
   int   checks = 0;
   int   failures = 0;
   rf_data_t d;

   regfile_scoreboard_if #(.WIDTH(32), .N(32), .NUM_RD(2)) ia ();
   regfile_scoreboard_if #(.WIDTH(32), .N(20), .NUM_RD(2)) ib ();

   regfile_scoreboard #(
      .WIDTH(32), .N(32), .NUM_RD(2), .ZERO_REG0(1), .BYPASS(1)
   ) u_a (
      .clk(clk), .rstn(rstn), .bus(ia)
   );

   regfile_scoreboard #(
      .WIDTH(32), .N(20), .NUM_RD(2), .ZERO_REG0(1), .BYPASS(0)
   ) u_b (
      .clk(clk), .rstn(rstn), .bus(ib)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ia.rd_en = '0;  ia.rd_addr = '0;
      ia.wr_en = 1'b0; ia.wr_addr = '0; ia.wr_data = '0;
      ia.rsv_en = 1'b0; ia.rsv_addr = '0; ia.flush = 1'b0;
      ib.rd_en = '0;  ib.rd_addr = '0;
      ib.wr_en = 1'b0; ib.wr_addr = '0; ib.wr_data = '0;
      ib.rsv_en = 1'b0; ib.rsv_addr = '0; ib.flush = 1'b0;
   endtask

   task automatic a_rsv(input int r);
      ia.rsv_en = 1'b1;
      ia.rsv_addr = 5'(r);
      tick();
      ia.rsv_en = 1'b0;
   endtask

   initial begin
      rstn = 1'b0;
      idle();
      ia.rd_en = 2'b11;
      ia.rd_addr[0] = 5'd5;
      #1;
      chk("rst_cnt_a", 32'(ia.busy_count), 32'd0);
      chk("rst_cnt_b", 32'(ib.busy_count), 32'd0);
      chk("rst_rd_a", ia.rd_data[0], 32'd0);
      chk("rst_busy_a", 32'(ia.rd_busy[0]), 32'd0);
      #11 rstn = 1'b1;
      idle();
      tick();

      // 1: write r5, read r5 and r0
      ia.wr_en = 1'b1; ia.wr_addr = 5'd5; ia.wr_data = 32'hDEAD_BEEF;
      tick();
      idle();
      ia.rd_en = 2'b11;
      ia.rd_addr[0] = 5'd5; ia.rd_addr[1] = 5'd0;
      #1;
      chk("t1_rd_r5", ia.rd_data[0], 32'hDEAD_BEEF);
      chk("t1_busy_r5", 32'(ia.rd_busy[0]), 32'd0);
      chk("t1_rd_r0", ia.rd_data[1], 32'd0);
      ia.rd_en = 2'b10;
      #1;
      chk("t1_rd_dis", ia.rd_data[0], 32'd0);

      // 2: reserve r7 twice, then release
      idle();
      ia.rsv_en = 1'b1; ia.rsv_addr = 5'd7;
      #1;
      chk("t2_rdy1", 32'(ia.rsv_ready), 32'd1);
      tick();
      ia.rd_en = 2'b01; ia.rd_addr[0] = 5'd7;
      #1;
      chk("t2_rdy2", 32'(ia.rsv_ready), 32'd0);
      chk("t2_busy", 32'(ia.rd_busy[0]), 32'd1);
      chk("t2_cnt1", 32'(ia.busy_count), 32'd1);
      tick();
      chk("t2_cnt_rej", 32'(ia.busy_count), 32'd1);
      ia.rsv_en = 1'b0;
      ia.wr_en = 1'b1; ia.wr_addr = 5'd7; ia.wr_data = 32'h1234;
      #1;
      chk("t2_byp", ia.rd_data[0], 32'h1234);
      chk("t2_byp_busy", 32'(ia.rd_busy[0]), 32'd0);
      tick();
      ia.wr_en = 1'b0;
      #1;
      chk("t2_cnt0", 32'(ia.busy_count), 32'd0);
      chk("t2_rd_r7", ia.rd_data[0], 32'h1234);

      // 3: same-cycle write/read, bypass vs none
      idle();
      ia.wr_en = 1'b1; ia.wr_addr = 5'd3; ia.wr_data = 32'hA5A5;
      ib.wr_en = 1'b1; ib.wr_addr = 5'd3; ib.wr_data = 32'hA5A5;
      ia.rd_en = 2'b01; ia.rd_addr[0] = 5'd3;
      ib.rd_en = 2'b01; ib.rd_addr[0] = 5'd3;
      #1;
      chk("t3_byp_a", ia.rd_data[0], 32'hA5A5);
      chk("t3_busy_a", 32'(ia.rd_busy[0]), 32'd0);
      chk("t3_old_b", ib.rd_data[0], 32'd0);
      tick();
      ib.wr_en = 1'b0;
      #1;
      chk("t3_new_b", ib.rd_data[0], 32'hA5A5);

      // 4: write and re-reserve the same busy register
      idle();
      a_rsv(9);
      chk("t4_cnt1", 32'(ia.busy_count), 32'd1);
      ia.wr_en = 1'b1; ia.wr_addr = 5'd9; ia.wr_data = 32'h55;
      ia.rsv_en = 1'b1; ia.rsv_addr = 5'd9;
      #1;
      chk("t4_rdy", 32'(ia.rsv_ready), 32'd1);
      tick();
      idle();
      ia.rd_en = 2'b01; ia.rd_addr[0] = 5'd9;
      #1;
      chk("t4_rd", ia.rd_data[0], 32'h55);
      chk("t4_busy", 32'(ia.rd_busy[0]), 32'd1);
      chk("t4_cnt", 32'(ia.busy_count), 32'd1);
      ia.wr_en = 1'b1; ia.wr_addr = 5'd9; ia.wr_data = 32'h66;
      tick();
      idle();
      #1;
      chk("t4_rel", 32'(ia.busy_count), 32'd0);

      // 5: reserve r1..r4, flush with write to r2
      for (int r = 1; r <= 4; r++) a_rsv(r);
      chk("t5_cnt4", 32'(ia.busy_count), 32'd4);
      ia.flush = 1'b1;
      ia.wr_en = 1'b1; ia.wr_addr = 5'd2; ia.wr_data = 32'h77;
      ia.rsv_en = 1'b1; ia.rsv_addr = 5'd5;
      #1;
      chk("t5_rdy_fl", 32'(ia.rsv_ready), 32'd0);
      tick();
      idle();
      ia.rd_en = 2'b11;
      ia.rd_addr[0] = 5'd2; ia.rd_addr[1] = 5'd4;
      #1;
      chk("t5_cnt0", 32'(ia.busy_count), 32'd0);
      chk("t5_rd_r2", ia.rd_data[0], 32'h77);
      chk("t5_busy_r2", 32'(ia.rd_busy[0]), 32'd0);
      chk("t5_busy_r4", 32'(ia.rd_busy[1]), 32'd0);

      // 6: N=20 range and zero-register limits
      ib.wr_en = 1'b1; ib.wr_addr = 5'd25; ib.wr_data = 32'hFFFF;
      ib.rsv_en = 1'b1; ib.rsv_addr = 5'd0;
      #1;
      chk("t6_rdy_r0", 32'(ib.rsv_ready), 32'd0);
      ib.rsv_addr = 5'd22;
      #1;
      chk("t6_rdy_oob", 32'(ib.rsv_ready), 32'd0);
      tick();
      ib.wr_en = 1'b1; ib.wr_addr = 5'd0; ib.wr_data = 32'h99;
      ib.rsv_en = 1'b1; ib.rsv_addr = 5'd19;
      #1;
      chk("t6_cnt0", 32'(ib.busy_count), 32'd0);
      chk("t6_rdy_r19", 32'(ib.rsv_ready), 32'd1);
      tick();
      idle();
      ib.rd_en = 2'b11;
      ib.rd_addr[0] = 5'd25; ib.rd_addr[1] = 5'd0;
      #1;
      chk("t6_rd_oob", ib.rd_data[0], 32'd0);
      chk("t6_rd_r0", ib.rd_data[1], 32'd0);
      chk("t6_cnt1", 32'(ib.busy_count), 32'd1);

      // reset in the middle of traffic
      idle();
      a_rsv(10);
      chk("rs_cnt1", 32'(ia.busy_count), 32'd1);
      ia.wr_en = 1'b1; ia.wr_addr = 5'd11; ia.wr_data = 32'h42;
      ia.rsv_en = 1'b1; ia.rsv_addr = 5'd12;
      ia.rd_en = 2'b11;
      ia.rd_addr[0] = 5'd5; ia.rd_addr[1] = 5'd10;
      #2 rstn = 1'b0;
      #1;
      chk("rs_cnt_a", 32'(ia.busy_count), 32'd0);
      chk("rs_cnt_b", 32'(ib.busy_count), 32'd0);
      chk("rs_rd_r5", ia.rd_data[0], 32'd0);
      chk("rs_busy_r10", 32'(ia.rd_busy[1]), 32'd0);
      idle();
      tick();
      #3 rstn = 1'b1;
      tick();
      ia.rd_en = 2'b01; ia.rd_addr[0] = 5'd2;
      d = 32'd0;
      #1;
      chk("rs_rd_r2", ia.rd_data[0], d);
      chk("rs_cnt_post", 32'(ia.busy_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
